rc4_prga_decrypt: RTL and testbench

Pseudo-random generation and decryption stage of the RC4 decryption circuit. It consumes the key-scheduled S array held in the 256x8 S working RAM. For each message byte it runs one RC4 PRGA step, fetches the ciphertext byte through the encrypted-memory interface FSM using the start/finish handshake, XORs the two, and writes the plaintext to the decrypted-message RAM. It sits downstream of key scheduling and is the sole client of the encrypted-memory interface.

---
 rtl/rc4_pkg.sv | 31 +++
 rtl/rc4_char_check.sv | 11 +
 rtl/rc4_prga_decrypt.sv | 186 ++++++++++++++++++
 tb/tb_rc4_prga_decrypt.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rc4_pkg.sv
// Shared definitions for the RC4 PRGA/decrypt stage: state encoding,
// default message length and the accepted plaintext character bounds.
package rc4_pkg;

    localparam int unsigned MSG_LEN_DEF = 32;

    localparam logic [7:0] CHAR_LO = 8'h61;
    localparam logic [7:0] CHAR_HI = 8'h7A;
    localparam logic [7:0] CHAR_SP = 8'h20;

    typedef enum logic [4:0] {
        ST_IDLE     = 5'd0,
        ST_RD_SI_S  = 5'd1,
        ST_RD_SI_W  = 5'd2,
        ST_RD_SI_G  = 5'd3,
        ST_RD_SJ_S  = 5'd4,
        ST_RD_SJ_W  = 5'd5,
        ST_RD_SJ_G  = 5'd6,
        ST_WR_SI    = 5'd7,
        ST_WR_SJ    = 5'd8,
        ST_RD_F_S   = 5'd9,
        ST_RD_F_W   = 5'd10,
        ST_RD_F_G   = 5'd11,
        ST_REQ_ENC  = 5'd12,
        ST_WAIT_ENC = 5'd13,
        ST_WR_DEC   = 5'd14,
        ST_NEXT     = 5'd15,
        ST_DONE     = 5'd16
    } state_t;

endpackage

// File: rtl/rc4_char_check.sv
// Combinational plaintext validator: lowercase a..z or space.
module rc4_char_check
    import rc4_pkg::*;
(
    input  logic [7:0] byte_i,
    output logic       ok_o
);

    assign ok_o = ((byte_i >= CHAR_LO) && (byte_i <= CHAR_HI)) || (byte_i == CHAR_SP);

endmodule

// File: rtl/rc4_prga_decrypt.sv
// RC4 PRGA + XOR decrypt stage over the S working RAM and encrypted-memory FSM.
// Optional plaintext check with early abort: define RC4_VALID_CHECK_EN.
module rc4_prga_decrypt
    import rc4_pkg::*;
#(
    parameter int unsigned MSG_LEN = MSG_LEN_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    output logic       finish,
    output logic       valid,
    output logic       enc_start,
    output logic [7:0] enc_adr,
    input  logic       enc_finish,
    input  logic [7:0] enc_data,
    output logic [7:0] s_addr,
    output logic [7:0] s_wdata,
    output logic       s_wren,
    input  logic [7:0] s_rdata,
    output logic [7:0] dec_addr,
    output logic [7:0] dec_wdata,
    output logic       dec_wren
);

    localparam logic [7:0] LAST_K = 8'(MSG_LEN - 1);

    state_t     state_q, state_d;
    logic [7:0] i_q, i_d;
    logic [7:0] j_q, j_d;
    logic [7:0] k_q, k_d;
    logic [7:0] si_q, si_d;
    logic [7:0] sj_q, sj_d;
    logic [7:0] f_q, f_d;
    logic [7:0] c_q, c_d;
    logic       valid_q, valid_d;

    logic [7:0] i_nxt;
    logic [7:0] j_nxt;
    logic [7:0] f_adr;
    logic [7:0] plain;
    logic       char_ok;

    assign i_nxt = i_q + 8'd1;
    assign j_nxt = j_q + si_q;
    assign f_adr = si_q + sj_q;
    assign plain = f_q ^ c_q;

`ifdef RC4_VALID_CHECK_EN
    rc4_char_check u_char_check (
        .byte_i (plain),
        .ok_o   (char_ok)
    );
`else
    assign char_ok = 1'b1;
`endif

    always_comb begin
        state_d   = state_q;
        i_d       = i_q;
        j_d       = j_q;
        k_d       = k_q;
        si_d      = si_q;
        sj_d      = sj_q;
        f_d       = f_q;
        c_d       = c_q;
        valid_d   = valid_q;
        s_addr    = '0;
        s_wdata   = '0;
        s_wren    = 1'b0;
        dec_wren  = 1'b0;
        enc_start = 1'b0;
        finish    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    i_d     = '0;
                    j_d     = '0;
                    k_d     = '0;
                    valid_d = 1'b0;
                    state_d = ST_RD_SI_S;
                end
            end
            // Each RAM read holds its address across SET/WAIT/GET.
            ST_RD_SI_S: begin s_addr = i_nxt; state_d = ST_RD_SI_W; end
            ST_RD_SI_W: begin s_addr = i_nxt; state_d = ST_RD_SI_G; end
            ST_RD_SI_G: begin
                s_addr  = i_nxt;
                i_d     = i_nxt;
                si_d    = s_rdata;
                state_d = ST_RD_SJ_S;
            end
            ST_RD_SJ_S: begin s_addr = j_nxt; state_d = ST_RD_SJ_W; end
            ST_RD_SJ_W: begin s_addr = j_nxt; state_d = ST_RD_SJ_G; end
            ST_RD_SJ_G: begin
                s_addr  = j_nxt;
                j_d     = j_nxt;
                sj_d    = s_rdata;
                state_d = ST_WR_SI;
            end
            ST_WR_SI: begin
                s_addr  = i_q;
                s_wdata = sj_q;
                s_wren  = 1'b1;
                state_d = ST_WR_SJ;
            end
            ST_WR_SJ: begin
                s_addr  = j_q;
                s_wdata = si_q;
                s_wren  = 1'b1;
                state_d = ST_RD_F_S;
            end
            ST_RD_F_S: begin s_addr = f_adr; state_d = ST_RD_F_W; end
            ST_RD_F_W: begin s_addr = f_adr; state_d = ST_RD_F_G; end
            ST_RD_F_G: begin
                s_addr  = f_adr;
                f_d     = s_rdata;
                state_d = ST_REQ_ENC;
            end
            ST_REQ_ENC: begin
                enc_start = 1'b1;
                state_d   = ST_WAIT_ENC;
            end
            ST_WAIT_ENC: begin
                if (enc_finish) begin
                    c_d     = enc_data;
                    state_d = ST_WR_DEC;
                end
            end
            ST_WR_DEC: begin
                if (char_ok) begin
                    dec_wren = 1'b1;
                    state_d  = ST_NEXT;
                end else begin
                    valid_d = 1'b0;
                    state_d = ST_DONE;
                end
            end
            ST_NEXT: begin
                k_d = k_q + 8'd1;
                if (k_q == LAST_K) begin
                    valid_d = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_RD_SI_S;
                end
            end
            ST_DONE: begin
                finish  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            i_q     <= '0;
            j_q     <= '0;
            k_q     <= '0;
            si_q    <= '0;
            sj_q    <= '0;
            f_q     <= '0;
            c_q     <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            k_q     <= k_d;
            si_q    <= si_d;
            sj_q    <= sj_d;
            f_q     <= f_d;
            c_q     <= c_d;
            valid_q <= valid_d;
        end
    end

    assign valid     = valid_q;
    assign enc_adr   = k_q;
    assign dec_addr  = k_q;
    assign dec_wdata = plain;

endmodule

// File: tb/tb_rc4_prga_decrypt.sv
// Self-checking bench: two DUTs (MSG_LEN=2 and MSG_LEN=256) against a plain RC4 model.
module tb_rc4_prga_decrypt;

`ifdef RC4_VALID_CHECK_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic       start      [2];
    logic       finish     [2];
    logic       valid      [2];
    logic       enc_start  [2];
    logic [7:0] enc_adr    [2];
    logic       enc_finish [2];
    logic [7:0] enc_data   [2];
    logic [7:0] s_addr     [2];
    logic [7:0] s_wdata    [2];
    logic       s_wren     [2];
    logic [7:0] s_rdata    [2];
    logic [7:0] dec_addr   [2];
    logic [7:0] dec_wdata  [2];
    logic       dec_wren   [2];

    rc4_prga_decrypt #(.MSG_LEN(2)) u_short (
        .clk(clk), .reset(reset), .start(start[0]), .finish(finish[0]), .valid(valid[0]),
        .enc_start(enc_start[0]), .enc_adr(enc_adr[0]), .enc_finish(enc_finish[0]),
        .enc_data(enc_data[0]), .s_addr(s_addr[0]), .s_wdata(s_wdata[0]), .s_wren(s_wren[0]),
        .s_rdata(s_rdata[0]), .dec_addr(dec_addr[0]), .dec_wdata(dec_wdata[0]),
        .dec_wren(dec_wren[0])
    );

    rc4_prga_decrypt #(.MSG_LEN(256)) u_long (
        .clk(clk), .reset(reset), .start(start[1]), .finish(finish[1]), .valid(valid[1]),
        .enc_start(enc_start[1]), .enc_adr(enc_adr[1]), .enc_finish(enc_finish[1]),
        .enc_data(enc_data[1]), .s_addr(s_addr[1]), .s_wdata(s_wdata[1]), .s_wren(s_wren[1]),
        .s_rdata(s_rdata[1]), .dec_addr(dec_addr[1]), .dec_wdata(dec_wdata[1]),
        .dec_wren(dec_wren[1])
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d (0x%0h) required=%0d (0x%0h) t=%0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    // Memories and encrypted-memory interface models
    logic [7:0] sram   [2][256];
    logic [7:0] dram   [2][256];
    logic [7:0] init_s [2][256];
    logic [7:0] encm   [2][256];
    logic       ld     [2];
    int         total_wr [2];
    int         enc_cnt  [2];

    always @(posedge clk) begin
        for (int n = 0; n < 2; n++) begin
            s_rdata[n] <= sram[n][s_addr[n]];
            if (ld[n]) begin
                for (int x = 0; x < 256; x++) begin
                    sram[n][x] = init_s[n][x];
                    dram[n][x] = 8'h00;
                end
                total_wr[n] = 0;
            end
            if (s_wren[n]) begin
                sram[n][s_addr[n]] = s_wdata[n];
                total_wr[n]++;
            end
            if (dec_wren[n]) begin
                dram[n][dec_addr[n]] = dec_wdata[n];
                total_wr[n]++;
            end
        end
    end

    always @(posedge clk or posedge reset) begin
        for (int n = 0; n < 2; n++) begin
            if (reset) begin
                enc_finish[n] <= 1'b0;
                enc_data[n]   <= 8'h00;
                enc_cnt[n]    <= 0;
            end else begin
                enc_finish[n] <= 1'b0;
                if (enc_start[n]) enc_cnt[n] <= 4;
                else if (enc_cnt[n] != 0) begin
                    enc_cnt[n] <= enc_cnt[n] - 1;
                    if (enc_cnt[n] == 1) begin
                        enc_finish[n] <= 1'b1;
                        enc_data[n]   <= encm[n][enc_adr[n]];
                    end
                end
            end
        end
    end

    // Reference model: plain RC4 over a copy of S
    int         ms [256];
    logic [7:0] exp_dec [2][256];
    logic [7:0] exp_s   [2][256];
    int         exp_n   [2];
    int         exp_ok  [2];

    function automatic bit printable(input int p);
        return (p >= 'h61 && p <= 'h7A) || p == 'h20;
    endfunction

    task automatic model_run(input int n, input int len);
        int i, j, t, f, p;
        for (int x = 0; x < 256; x++) ms[x] = int'(sram[n][x]);
        i = 0; j = 0;
        exp_n[n] = 0; exp_ok[n] = 1;
        for (int k = 0; k < len; k++) begin
            i = (i + 1) % 256;
            j = (j + ms[i]) % 256;
            t = ms[i]; ms[i] = ms[j]; ms[j] = t;
            f = ms[(ms[i] + ms[j]) % 256];
            p = f ^ int'(encm[n][k]);
            if (CHK_EN && !printable(p)) begin
                exp_ok[n] = 0;
                break;
            end
            exp_dec[n][k] = 8'(p);
            exp_n[n] = k + 1;
        end
        for (int x = 0; x < 256; x++) exp_s[n][x] = 8'(ms[x]);
    endtask

    // Per-cycle compare process
    int wr_cnt   [2];
    int done_cnt [2];
    bit enc_busy [2];

    always @(negedge clk) begin
        for (int n = 0; n < 2; n++) begin
            if (reset) begin
                wr_cnt[n]   = 0;
                enc_busy[n] = 1'b0;
            end else begin
                if (dec_wren[n]) begin
                    chk("dec_write_expected", int'(wr_cnt[n] < exp_n[n]), 1);
                    chk("dec_addr", int'(dec_addr[n]), wr_cnt[n] % 256);
                    chk("dec_wdata", int'(dec_wdata[n]), int'(exp_dec[n][wr_cnt[n] % 256]));
                    chk("single_wren", int'(s_wren[n]), 0);
                    wr_cnt[n]++;
                end
                if (enc_start[n]) begin
                    chk("enc_adr", int'(enc_adr[n]), wr_cnt[n] % 256);
                    chk("enc_no_reissue", int'(enc_busy[n]), 0);
                    enc_busy[n] = 1'b1;
                end
                if (enc_finish[n]) enc_busy[n] = 1'b0;
                if (finish[n]) begin
                    done_cnt[n] = wr_cnt[n];
                    wr_cnt[n]   = 0;
                end
            end
        end
    end

    function automatic int outs_nonzero(input int n);
        return int'(|{finish[n], valid[n], enc_start[n], enc_adr[n], s_addr[n], s_wdata[n],
                      s_wren[n], dec_addr[n], dec_wdata[n], dec_wren[n]});
    endfunction

    task automatic load(input int n);
        @(negedge clk); ld[n] = 1'b1;
        @(negedge clk); ld[n] = 1'b0;
    endtask

    task automatic run(input int n, input int len, input bit mid_start, output int cyc);
        int exp_lat, mism;
        model_run(n, len);
        exp_lat = exp_ok[n] ? 19 * len : 19 * exp_n[n] + 18;
        @(negedge clk); start[n] = 1'b1;
        @(posedge clk); #1 start[n] = 1'b0;
        @(negedge clk);
        chk("valid_cleared_on_start", int'(valid[n]), 0);
        cyc = 0;
        while (cyc < 19 * len + 100) begin
            @(posedge clk); cyc++;
            @(negedge clk);
            if (finish[n]) break;
            start[n] = (mid_start && cyc == 700);
        end
        start[n] = 1'b0;
        chk("finish_latency", cyc, exp_lat);
        chk("valid_at_finish", int'(valid[n]), exp_ok[n]);
        @(posedge clk); @(negedge clk);
        chk("finish_one_cycle", int'(finish[n]), 0);
        chk("valid_held", int'(valid[n]), exp_ok[n]);
        chk("dec_write_count", done_cnt[n], exp_n[n]);
        mism = 0;
        for (int x = 0; x < 256; x++) if (sram[n][x] !== exp_s[n][x]) mism++;
        chk("s_final_mismatches", mism, 0);
    endtask

    initial begin
        int cyc, snap;
        reset = 1'b1;
        for (int n = 0; n < 2; n++) begin start[n] = 1'b0; ld[n] = 1'b0; end
        for (int n = 0; n < 2; n++)
            for (int x = 0; x < 256; x++) begin init_s[n][x] = 8'(x); encm[n][x] = 8'h00; end
        repeat (2) @(negedge clk);
        chk("reset_outputs_short", outs_nonzero(0), 0);
        chk("reset_outputs_long", outs_nonzero(1), 0);
        reset = 1'b0;

        // Directed: identity S, two bytes
`ifndef RC4_VALID_CHECK_EN
        load(0);
        model_run(0, 2);
        chk("model_dec0", int'(exp_dec[0][0]), 'h02);
        chk("model_dec1", int'(exp_dec[0][1]), 'h05);
        chk("model_s2", int'(exp_s[0][2]), 'h03);
        chk("model_s3", int'(exp_s[0][3]), 'h02);
        run(0, 2, 1'b0, cyc);
        chk("short_latency", cyc, 38);
        chk("dram0", int'(dram[0][0]), 'h02);
        chk("dram1", int'(dram[0][1]), 'h05);
        chk("sram2", int'(sram[0][2]), 'h03);
        chk("sram3", int'(sram[0][3]), 'h02);
        chk("valid_after_run", int'(valid[0]), 1);
`else
        encm[0][0] = 8'h63; encm[0][1] = 8'h64;
        load(0);
        model_run(0, 2);
        chk("model_dec0", int'(exp_dec[0][0]), 'h61);
        chk("model_dec1", int'(exp_dec[0][1]), 'h61);
        chk("model_ok", exp_ok[0], 1);
        run(0, 2, 1'b0, cyc);
        chk("short_latency", cyc, 38);
        chk("dram0", int'(dram[0][0]), 'h61);
        chk("dram1", int'(dram[0][1]), 'h61);
        chk("valid_after_run", int'(valid[0]), 1);
        encm[0][0] = 8'h00; encm[0][1] = 8'h00;
        load(0);
        model_run(0, 2);
        chk("model_reject", exp_ok[0], 0);
        run(0, 2, 1'b0, cyc);
        chk("abort_latency", cyc, 18);
        chk("abort_valid", int'(valid[0]), 0);
        chk("abort_total_writes", total_wr[0], 2);
`endif

        // Reset in RD_F of k=1, then rerun from k=0
        load(0);
        @(negedge clk); start[0] = 1'b1;
        @(posedge clk); #1 start[0] = 1'b0;
        repeat (28) @(posedge clk);
        #2 reset = 1'b1;
        #1 chk("midrun_reset_outputs", outs_nonzero(0), 0);
        snap = total_wr[0];
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        chk("no_writes_after_reset", total_wr[0], snap);
        run(0, 2, 1'b0, cyc);

        // Randomized short runs
        for (int r = 0; r < 4; r++) begin
            for (int x = 0; x < 256; x++) begin
                init_s[0][x] = 8'($urandom_range(0, 255));
                encm[0][x]   = 8'($urandom_range(0, 255));
            end
            load(0);
            run(0, 2, 1'b0, cyc);
        end

        // Full 256-byte run with a stray start mid-run
        for (int x = 0; x < 256; x++) begin
            init_s[1][x] = 8'($urandom_range(0, 255));
            encm[1][x]   = 8'($urandom_range(0, 255));
        end
        load(1);
        run(1, 256, 1'b1, cyc);
        snap = total_wr[1];
        repeat (10) @(negedge clk);
        chk("long_no_extra_writes", total_wr[1], snap);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
